// File: rtl/prim_alert_sender_mux.sv
// rtl/prim_alert_sender_mux.sv - multiplexes several alert channels onto one differential alert link
module prim_alert_sender_mux #(
  parameter int unsigned          NumAlerts     = 4,
  parameter logic [NumAlerts-1:0] IsFatal       = '0,
  parameter int unsigned          TimeoutCycles = 64,
  parameter int unsigned          PauseCycles   = 2,
  localparam int unsigned         IdxW          = (NumAlerts > 1) ? $clog2(NumAlerts) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumAlerts-1:0] alert_req_i,
  input  logic [NumAlerts-1:0] alert_test_i,
  output logic [NumAlerts-1:0] alert_ack_o,
  output logic [NumAlerts-1:0] alert_state_o,
  input  logic                 ping_p_i,
  input  logic                 ping_n_i,
  input  logic                 ack_p_i,
  input  logic                 ack_n_i,
  output logic                 alert_p_o,
  output logic                 alert_n_o,
  output logic [IdxW-1:0]      alert_idx_o,
  output logic                 timeout_o
);

  // A zero pause would make the pause counter wrap; one idle cycle is the floor.
  localparam int unsigned PauseLen = (PauseCycles < 1) ? 1 : PauseCycles;
  localparam int unsigned CntMax   = (TimeoutCycles > PauseLen) ? TimeoutCycles : PauseLen;
  localparam int unsigned CntW     = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] PauseLast   = CntW'(PauseLen - 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StAlertHs1 = 3'd1,
    StAlertHs2 = 3'd2,
    StPingHs1  = 3'd3,
    StPingHs2  = 3'd4,
    StPause    = 3'd5,
    StSigInt   = 3'd6
  } state_e;

  state_e                 state_q;
  logic                   alert_p_q, alert_n_q;
  logic [IdxW-1:0]        alert_idx_q;
  logic [IdxW-1:0]        last_grant_q;
  logic [CntW-1:0]        cnt_q;
  logic                   timeout_q;

  logic                   ping_p_q, ping_n_q, ping_pp_q, ping_pn_q;
  logic                   ack_p_q, ack_n_q;

  logic [NumAlerts-1:0]   set_q, set_d;
  logic [NumAlerts-1:0]   test_q, test_d;
  logic [NumAlerts-1:0]   ack_q, ack_d;
  logic                   ping_q, ping_d;

  logic                   sigint;
  logic                   ack_level;
  logic                   ping_event;
  logic                   alert_done;
  logic                   ping_done;
  logic                   timeout_hit;
  logic [NumAlerts-1:0]   done_mask;
  logic [NumAlerts-1:0]   pend;
  logic                   grant_valid;
  logic [IdxW-1:0]        grant_idx;
  logic [IdxW-1:0]        cand;

  // Single register stage on both incoming differential pairs plus one history stage for ping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ping_p_q  <= 1'b0;
      ping_n_q  <= 1'b1;
      ping_pp_q <= 1'b0;
      ping_pn_q <= 1'b1;
      ack_p_q   <= 1'b0;
      ack_n_q   <= 1'b1;
    end else begin
      ping_p_q  <= ping_p_i;
      ping_n_q  <= ping_n_i;
      ping_pp_q <= ping_p_q;
      ping_pn_q <= ping_n_q;
      ack_p_q   <= ack_p_i;
      ack_n_q   <= ack_n_i;
    end
  end

  assign sigint     = (ping_p_q == ping_n_q) || (ack_p_q == ack_n_q);
  assign ack_level  = ack_p_q && (ack_p_q != ack_n_q);
  assign ping_event = (ping_p_q != ping_n_q) && (ping_pp_q != ping_pn_q) && (ping_p_q != ping_pp_q);

  // A handshake completes when the receiver drops ack in phase two, unless integrity failed.
  assign alert_done  = (state_q == StAlertHs2) && !sigint && !ack_level;
  assign ping_done   = (state_q == StPingHs2) && !sigint && !ack_level;
  assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == TimeoutLast);

  // Completion mask for the granted channel.
  always_comb begin
    done_mask = '0;
    if (alert_done) begin
      done_mask[alert_idx_q] = 1'b1;
    end
  end

  // Next-state for the per-channel latches; a request arriving with completion re-latches.
  always_comb begin
    set_d  = alert_req_i | (set_q & ~(done_mask & ~IsFatal));
    test_d = alert_test_i | (test_q & ~done_mask);
    ack_d  = done_mask & set_q;
    ping_d = ping_event | (ping_q & ~ping_done);
  end

  // Per-channel alert, test and ping latches and the ack pulse register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      set_q  <= '0;
      test_q <= '0;
      ack_q  <= '0;
      ping_q <= 1'b0;
    end else begin
      set_q  <= set_d;
      test_q <= test_d;
      ack_q  <= ack_d;
      ping_q <= ping_d;
    end
  end

  assign pend = set_q | test_q | alert_req_i | alert_test_i;

  // Round-robin pick of the first pending channel after the last grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < int'(NumAlerts); k++) begin
      cand = IdxW'((int'(last_grant_q) + 1 + k) % int'(NumAlerts));
      if (!grant_valid && pend[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Handshake sequencer with registered link outputs, index and timeout flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      alert_p_q    <= 1'b0;
      alert_n_q    <= 1'b1;
      alert_idx_q  <= '0;
      last_grant_q <= IdxW'(NumAlerts - 1);
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else if (sigint && (state_q != StSigInt)) begin
      state_q   <= StSigInt;
      alert_p_q <= 1'b0;
      alert_n_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (grant_valid) begin
            state_q      <= StAlertHs1;
            alert_p_q    <= 1'b1;
            alert_n_q    <= 1'b0;
            alert_idx_q  <= grant_idx;
            last_grant_q <= grant_idx;
          end else if (ping_q) begin
            state_q     <= StPingHs1;
            alert_p_q   <= 1'b1;
            alert_n_q   <= 1'b0;
            alert_idx_q <= '0;
          end
        end
        StAlertHs1, StPingHs1: begin
          if (ack_level) begin
            state_q   <= (state_q == StAlertHs1) ? StAlertHs2 : StPingHs2;
            alert_p_q <= 1'b0;
            alert_n_q <= 1'b1;
            cnt_q     <= '0;
          end else if (timeout_hit) begin
            state_q   <= StPause;
            alert_p_q <= 1'b0;
            alert_n_q <= 1'b1;
            timeout_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StAlertHs2, StPingHs2: begin
          if (!ack_level) begin
            state_q <= StPause;
            cnt_q   <= '0;
          end else if (timeout_hit) begin
            state_q   <= StPause;
            timeout_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StPause: begin
          alert_p_q <= 1'b0;
          alert_n_q <= 1'b1;
          if (cnt_q == PauseLast) begin
            state_q     <= StIdle;
            alert_idx_q <= '0;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StSigInt: begin
          if (sigint) begin
            alert_p_q <= ~alert_p_q;
            alert_n_q <= ~alert_p_q;
          end else begin
            state_q     <= StIdle;
            alert_p_q   <= 1'b0;
            alert_n_q   <= 1'b1;
            alert_idx_q <= '0;
            cnt_q       <= '0;
          end
        end
        default: begin
          state_q     <= StIdle;
          alert_p_q   <= 1'b0;
          alert_n_q   <= 1'b1;
          alert_idx_q <= '0;
          cnt_q       <= '0;
        end
      endcase
    end
  end

  assign alert_p_o     = alert_p_q;
  assign alert_n_o     = alert_n_q;
  assign alert_idx_o   = alert_idx_q;
  assign timeout_o     = timeout_q;
  assign alert_state_o = set_q;
  assign alert_ack_o   = ack_q;

endmodule
